// File: rtl/mr_wb_pkg.sv
// mr_wb_pkg: shared types for the core memory interconnect Wishbone arbiter.
//   owner_e    : arbiter ownership state (IDLE / OWN_A / OWN_B)
//   OWNER_*    : encodings driven on o_owner
//   wb_req_t   : master-side pipelined Wishbone request (cyc, stb, we, adr, dat, sel)
//   wb_rsp_t   : master-side response (ack, err, stall)
// Payload fields are sized for the widest bus in the system; each user keeps
// only the low AW / DW / SELW bits it actually has.
package mr_wb_pkg;

    localparam int WB_AW_MAX   = 64;
    localparam int WB_DW_MAX   = 128;
    localparam int WB_SELW_MAX = WB_DW_MAX / 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_OWN_A = 2'b01,
        ST_OWN_B = 2'b10
    } owner_e;

    localparam logic [1:0] OWNER_IDLE = 2'b00;
    localparam logic [1:0] OWNER_A    = 2'b01;
    localparam logic [1:0] OWNER_B    = 2'b10;

    typedef struct packed {
        logic                   cyc;
        logic                   stb;
        logic                   we;
        logic [WB_AW_MAX-1:0]   adr;
        logic [WB_DW_MAX-1:0]   dat;
        logic [WB_SELW_MAX-1:0] sel;
    } wb_req_t;

    typedef struct packed {
        logic ack;
        logic err;
        logic stall;
    } wb_rsp_t;

    localparam wb_req_t WB_REQ_NONE    = '0;
    // A master that does not own the bus sees a permanently stalled slave.
    localparam wb_rsp_t WB_RSP_BLOCKED = '{ack: 1'b0, err: 1'b0, stall: 1'b1};

    function automatic logic [1:0] owner_code(input owner_e st);
        case (st)
            ST_OWN_A: owner_code = OWNER_A;
            ST_OWN_B: owner_code = OWNER_B;
            default:  owner_code = OWNER_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/mr_wb_outst_cnt.sv
// mr_wb_outst_cnt: in-flight request counter for one bus tenure.
//   clk, rst_n : clock, asynchronous active-low reset
//   inc        : a request was accepted by the slave this cycle
//   dec        : a completion (ack or err) arrived this cycle
//   clr        : synchronous clear (tenure ended or aborted); wins over inc/dec
//   count      : current in-flight count, 0..MAX_OUTST
//   full/empty : count == MAX_OUTST / count == 0
// A completion while empty is ignored so the count can never underflow.
// The owner's stall is forced while full, so inc never arrives when full.
module mr_wb_outst_cnt #(
    parameter int MAX_OUTST = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         inc,
    input  logic                         dec,
    input  logic                         clr,
    output logic [$clog2(MAX_OUTST):0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int CW = $clog2(MAX_OUTST) + 1;

    logic [CW-1:0] count_q;
    logic          dec_eff;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(MAX_OUTST));
    assign dec_eff = dec & ~empty;
    assign count   = count_q;

    // NOTE: sequential state is written with non-blocking assignments only, so
    // every flop samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (inc && !dec_eff) begin
            count_q <= count_q + 1'b1;
        end else if (dec_eff && !inc) begin
            count_q <= count_q - 1'b1;
        end
    end

endmodule

// File: rtl/mr_wb_prio_arb.sv
// mr_wb_prio_arb: two-master to one-slave pipelined Wishbone arbiter.
//   Master A (instruction fetch) and master B (load/store) share the unified
//   RAM. Ownership is granted per CYC tenure and never moves while the owner
//   holds CYC. Simultaneous requests from idle go to B when PRIO_B=1, else A.
//   On release the waiting master always wins over the releasing one.
// Ports:
//   clk, rst                     : clock, asynchronous active-low reset
//   i_a_* / o_a_*                : master A request in, response out
//   i_b_* / o_b_*                : master B request in, response out
//   o_cyc..o_sel                 : slave request (combinational from owner)
//   i_ack, i_err, i_stall        : slave response
//   o_owner                      : registered owner, 00 idle / 01 A / 10 B
//   o_outst                      : registered in-flight request count
module mr_wb_prio_arb
    import mr_wb_pkg::*;
#(
    parameter int AW        = 30,
    parameter int DW        = 32,
    parameter int MAX_OUTST = 4,
    parameter int PRIO_B    = 1
) (
    input  logic                       clk,
    input  logic                       rst,

    input  logic                       i_a_cyc,
    input  logic                       i_a_stb,
    input  logic                       i_a_we,
    input  logic [AW-1:0]              i_a_adr,
    input  logic [DW-1:0]              i_a_dat,
    input  logic [DW/8-1:0]            i_a_sel,
    output logic                       o_a_ack,
    output logic                       o_a_err,
    output logic                       o_a_stall,

    input  logic                       i_b_cyc,
    input  logic                       i_b_stb,
    input  logic                       i_b_we,
    input  logic [AW-1:0]              i_b_adr,
    input  logic [DW-1:0]              i_b_dat,
    input  logic [DW/8-1:0]            i_b_sel,
    output logic                       o_b_ack,
    output logic                       o_b_err,
    output logic                       o_b_stall,

    output logic                       o_cyc,
    output logic                       o_stb,
    output logic                       o_we,
    output logic [AW-1:0]              o_adr,
    output logic [DW-1:0]              o_dat,
    output logic [DW/8-1:0]            o_sel,
    input  logic                       i_ack,
    input  logic                       i_err,
    input  logic                       i_stall,

    output logic [1:0]                 o_owner,
    output logic [$clog2(MAX_OUTST):0] o_outst
);

    localparam int SELW = DW / 8;

    owner_e  state_q;
    owner_e  state_d;

    wb_req_t a_req;
    wb_req_t b_req;
    wb_req_t own_req;
    wb_rsp_t a_rsp;
    wb_rsp_t b_rsp;

    logic    own_stall;
    logic    accept;
    logic    done;
    logic    rsp_live;
    logic    cnt_full;
    logic    cnt_empty;
    logic    unused_hi;

    // ------------------------------------------------------------------
    // Request packing and owner mux
    // ------------------------------------------------------------------
    assign a_req = '{cyc: i_a_cyc, stb: i_a_stb, we: i_a_we,
                     adr: WB_AW_MAX'(i_a_adr), dat: WB_DW_MAX'(i_a_dat),
                     sel: WB_SELW_MAX'(i_a_sel)};
    assign b_req = '{cyc: i_b_cyc, stb: i_b_stb, we: i_b_we,
                     adr: WB_AW_MAX'(i_b_adr), dat: WB_DW_MAX'(i_b_dat),
                     sel: WB_SELW_MAX'(i_b_sel)};

    // NOTE: every signal written in an always_comb gets a default first, so no
    // path through the case can leave it unassigned and infer a latch.
    always_comb begin
        own_req = WB_REQ_NONE;
        case (state_q)
            ST_OWN_A: own_req = a_req;
            ST_OWN_B: own_req = b_req;
            default:  own_req = WB_REQ_NONE;
        endcase
    end

    assign o_cyc = own_req.cyc;
    assign o_stb = own_req.stb;
    assign o_we  = own_req.we;
    assign o_adr = own_req.adr[AW-1:0];
    assign o_dat = own_req.dat[DW-1:0];
    assign o_sel = own_req.sel[SELW-1:0];

    // Payload bits above AW/DW/SELW are always zero and intentionally dropped.
    assign unused_hi = ^{own_req.adr, own_req.dat, own_req.sel};

    // ------------------------------------------------------------------
    // Outstanding tracking
    // ------------------------------------------------------------------
    assign own_stall = i_stall | cnt_full;
    assign accept    = own_req.stb & ~own_stall;
    assign done      = i_ack | i_err;
    // Responses are delivered only while the owner still holds CYC and has
    // something in flight; late responses after an abort, or stale ones seen
    // by a freshly granted master, are dropped here.
    assign rsp_live  = own_req.cyc & ~cnt_empty;

    // Owner dropping CYC ends the tenure: with requests still in flight this
    // is an abort, and the count restarts from zero for the next owner.
    mr_wb_outst_cnt #(
        .MAX_OUTST (MAX_OUTST)
    ) u_outst_cnt (
        .clk   (clk),
        .rst_n (rst),
        .inc   (accept),
        .dec   (done),
        .clr   (~own_req.cyc),
        .count (o_outst),
        .full  (cnt_full),
        .empty (cnt_empty)
    );

    // ------------------------------------------------------------------
    // Response routing
    // ------------------------------------------------------------------
    always_comb begin
        a_rsp = WB_RSP_BLOCKED;
        b_rsp = WB_RSP_BLOCKED;
        case (state_q)
            ST_OWN_A: a_rsp = '{ack: i_ack & rsp_live, err: i_err & rsp_live,
                                stall: own_stall};
            ST_OWN_B: b_rsp = '{ack: i_ack & rsp_live, err: i_err & rsp_live,
                                stall: own_stall};
            default: ;
        endcase
    end

    assign o_a_ack   = a_rsp.ack;
    assign o_a_err   = a_rsp.err;
    assign o_a_stall = a_rsp.stall;
    assign o_b_ack   = b_rsp.ack;
    assign o_b_err   = b_rsp.err;
    assign o_b_stall = b_rsp.stall;

    // ------------------------------------------------------------------
    // Ownership FSM
    // ------------------------------------------------------------------
    // Releasing always hands to the other master if it is waiting, even if
    // the releaser re-raises CYC in the same cycle (it sees CYC low here).
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (i_a_cyc && i_b_cyc) begin
                    state_d = (PRIO_B != 0) ? ST_OWN_B : ST_OWN_A;
                end else if (i_a_cyc) begin
                    state_d = ST_OWN_A;
                end else if (i_b_cyc) begin
                    state_d = ST_OWN_B;
                end
            end
            ST_OWN_A: begin
                if (!i_a_cyc) begin
                    state_d = i_b_cyc ? ST_OWN_B : ST_IDLE;
                end
            end
            ST_OWN_B: begin
                if (!i_b_cyc) begin
                    state_d = i_a_cyc ? ST_OWN_A : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: only control state is reset; the datapath is purely combinational,
    // so reset alone returns every slave-side output to its idle value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign o_owner = owner_code(state_q);

endmodule

// File: tb/tb_mr_wb_prio_arb.sv
// tb_mr_wb_prio_arb: self-checking bench for mr_wb_prio_arb.
// A behavioural model (owner number + in-flight integer) predicts every DUT
// output each cycle; directed scenarios add explicit expectations on top.
module tb_mr_wb_prio_arb;

    localparam int AW        = 30;
    localparam int DW        = 32;
    localparam int SELW      = DW / 8;
    localparam int MAX_OUTST = 4;
    localparam int PRIO_B    = 1;
    localparam int OW        = $clog2(MAX_OUTST) + 1;
    localparam int VW        = 3 + AW + DW + SELW + 6 + 2 + OW;

    logic clk;
    logic rst;

    logic            a_cyc, a_stb, a_we;
    logic [AW-1:0]   a_adr;
    logic [DW-1:0]   a_dat;
    logic [SELW-1:0] a_sel;
    logic            b_cyc, b_stb, b_we;
    logic [AW-1:0]   b_adr;
    logic [DW-1:0]   b_dat;
    logic [SELW-1:0] b_sel;
    logic            s_ack, s_err, s_stall;

    logic            o_a_ack, o_a_err, o_a_stall;
    logic            o_b_ack, o_b_err, o_b_stall;
    logic            o_cyc, o_stb, o_we;
    logic [AW-1:0]   o_adr;
    logic [DW-1:0]   o_dat;
    logic [SELW-1:0] o_sel;
    logic [1:0]      o_owner;
    logic [OW-1:0]   o_outst;

    // model: 0 = no owner, 1 = A, 2 = B
    int   m_owner;
    int   m_outst;
    int   m_acc_cnt;
    logic m_last_acc;
    bit   auto_ack;

    int   n_checks;
    int   n_fail;

    mr_wb_prio_arb #(
        .AW(AW), .DW(DW), .MAX_OUTST(MAX_OUTST), .PRIO_B(PRIO_B)
    ) dut (
        .clk(clk), .rst(rst),
        .i_a_cyc(a_cyc), .i_a_stb(a_stb), .i_a_we(a_we), .i_a_adr(a_adr),
        .i_a_dat(a_dat), .i_a_sel(a_sel),
        .o_a_ack(o_a_ack), .o_a_err(o_a_err), .o_a_stall(o_a_stall),
        .i_b_cyc(b_cyc), .i_b_stb(b_stb), .i_b_we(b_we), .i_b_adr(b_adr),
        .i_b_dat(b_dat), .i_b_sel(b_sel),
        .o_b_ack(o_b_ack), .o_b_err(o_b_err), .o_b_stall(o_b_stall),
        .o_cyc(o_cyc), .o_stb(o_stb), .o_we(o_we), .o_adr(o_adr),
        .o_dat(o_dat), .o_sel(o_sel),
        .i_ack(s_ack), .i_err(s_err), .i_stall(s_stall),
        .o_owner(o_owner), .o_outst(o_outst)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------------------------------------------------------- model
    task automatic model_reset();
        m_owner    = 0;
        m_outst    = 0;
        m_last_acc = 1'b0;
    endtask

    // One clock edge of the arbiter's rules, applied to the inputs present
    // just before the edge.
    task automatic model_edge();
        logic oc, os, acc, comp;
        int   nxt;
        oc = (m_owner == 1) ? a_cyc : (m_owner == 2) ? b_cyc : 1'b0;
        os = (m_owner == 1) ? a_stb : (m_owner == 2) ? b_stb : 1'b0;
        m_last_acc = 1'b0;
        if (m_owner != 0 && oc) begin
            acc  = os && !s_stall && (m_outst < MAX_OUTST);
            comp = (s_ack || s_err) && (m_outst > 0);
            m_outst = m_outst + (acc ? 1 : 0) - (comp ? 1 : 0);
            m_last_acc = acc;
            if (acc) m_acc_cnt++;
        end else begin
            m_outst = 0;
        end
        nxt = m_owner;
        if (m_owner == 0) begin
            if (a_cyc && b_cyc) nxt = (PRIO_B != 0) ? 2 : 1;
            else if (a_cyc)     nxt = 1;
            else if (b_cyc)     nxt = 2;
        end else if (m_owner == 1 && !a_cyc) begin
            nxt = b_cyc ? 2 : 0;
        end else if (m_owner == 2 && !b_cyc) begin
            nxt = a_cyc ? 1 : 0;
        end
        m_owner = nxt;
    endtask

    function automatic logic [VW-1:0] exp_vec();
        logic            c, s, w, stl, ok;
        logic [AW-1:0]   ad;
        logic [DW-1:0]   d;
        logic [SELW-1:0] sl;
        logic [1:0]      own;
        c = 1'b0; s = 1'b0; w = 1'b0; ad = '0; d = '0; sl = '0; own = 2'b00;
        if (m_owner == 1) begin
            c = a_cyc; s = a_stb; w = a_we; ad = a_adr; d = a_dat; sl = a_sel; own = 2'b01;
        end else if (m_owner == 2) begin
            c = b_cyc; s = b_stb; w = b_we; ad = b_adr; d = b_dat; sl = b_sel; own = 2'b10;
        end
        stl = s_stall || (m_outst == MAX_OUTST);
        ok  = c && (m_outst > 0);
        return {c, s, w, ad, d, sl,
                (m_owner == 1) && ok && s_ack, (m_owner == 1) && ok && s_err,
                (m_owner == 1) ? stl : 1'b1,
                (m_owner == 2) && ok && s_ack, (m_owner == 2) && ok && s_err,
                (m_owner == 2) ? stl : 1'b1,
                own, OW'(m_outst)};
    endfunction

    function automatic logic [VW-1:0] obs_vec();
        return {o_cyc, o_stb, o_we, o_adr, o_dat, o_sel,
                o_a_ack, o_a_err, o_a_stall, o_b_ack, o_b_err, o_b_stall,
                o_owner, o_outst};
    endfunction

    task automatic tick();
        @(posedge clk);
        if (!rst) model_reset();
        else      model_edge();
        #1;
        if (auto_ack) s_ack = m_last_acc;
    endtask

    task automatic idle_inputs();
        a_cyc = 1'b0; a_stb = 1'b0; a_we = 1'b0; a_adr = '0; a_dat = '0; a_sel = '0;
        b_cyc = 1'b0; b_stb = 1'b0; b_we = 1'b0; b_adr = '0; b_dat = '0; b_sel = '0;
        s_ack = 1'b0; s_err = 1'b0; s_stall = 1'b0;
    endtask

    // ---------------------------------------------------------------- tests
    task automatic test_reset();
        rst = 1'b0;
        idle_inputs();
        model_reset();
        #2;
        n_checks++;
        if (obs_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL reset_vec: got %h want %h", obs_vec(), exp_vec());
        end
        n_checks++;
        if (o_a_stall !== 1'b1 || o_b_stall !== 1'b1 || o_cyc !== 1'b0 ||
            o_owner !== 2'b00 || o_outst !== '0) begin
            n_fail++;
            $display("FAIL reset_state: stall_a=%b stall_b=%b cyc=%b owner=%b outst=%0d want 1 1 0 00 0",
                     o_a_stall, o_b_stall, o_cyc, o_owner, o_outst);
        end
        tick();
        rst = 1'b1;
    endtask

    task automatic test_single_a();
        int peak;
        peak = 0;
        auto_ack = 1'b1;
        for (int c = 0; c < 7; c++) begin
            a_cyc = (c <= 4);
            a_stb = (c <= 3);
            a_we  = 1'b0;
            a_adr = AW'(32'h100 + c);
            a_sel = '1;
            #3;
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL single_a_vec c%0d: got %h want %h", c, obs_vec(), exp_vec());
            end
            if (c == 0) begin
                n_checks++;
                if (o_a_stall !== 1'b1 || o_owner !== 2'b00) begin
                    n_fail++; $display("FAIL single_a_req: stall=%b owner=%b want 1 00", o_a_stall, o_owner);
                end
            end
            if (c == 1) begin
                n_checks++;
                if (o_owner !== 2'b01) begin
                    n_fail++; $display("FAIL single_a_grant: owner=%b want 01", o_owner);
                end
            end
            if (c >= 1 && c <= 3) begin
                n_checks++;
                if (o_stb !== 1'b1 || o_a_stall !== 1'b0) begin
                    n_fail++; $display("FAIL single_a_stb c%0d: stb=%b stall=%b want 1 0", c, o_stb, o_a_stall);
                end
            end
            if (int'(o_outst) > peak) peak = int'(o_outst);
            if (c == 6) begin
                n_checks++;
                if (o_owner !== 2'b00 || o_outst !== '0) begin
                    n_fail++; $display("FAIL single_a_end: owner=%b outst=%0d want 00 0", o_owner, o_outst);
                end
            end
            tick();
        end
        auto_ack = 1'b0;
        s_ack = 1'b0;
        n_checks++;
        if (peak < 1 || peak > 2) begin
            n_fail++; $display("FAIL single_a_peak: peak=%0d want 1..2", peak);
        end
    endtask

    task automatic test_prio_handover();
        auto_ack = 1'b1;
        for (int c = 0; c < 10; c++) begin
            b_cyc = (c <= 3); b_stb = (c <= 2); b_we = 1'b1;
            b_adr = AW'(32'h200 + c); b_dat = 32'hB000_0000 + 32'(c); b_sel = 4'hF;
            a_cyc = (c <= 7); a_stb = (c <= 6); a_we = 1'b0;
            a_adr = AW'(32'h300 + c); a_sel = 4'hF;
            #3;
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL prio_vec c%0d: got %h want %h", c, obs_vec(), exp_vec());
            end
            if (c == 1) begin
                n_checks++;
                if (o_owner !== 2'b10 || o_a_stall !== 1'b1) begin
                    n_fail++; $display("FAIL prio_winner: owner=%b a_stall=%b want 10 1", o_owner, o_a_stall);
                end
            end
            if (c == 4) begin
                n_checks++;
                if (o_owner !== 2'b10 || o_cyc !== 1'b0) begin
                    n_fail++; $display("FAIL prio_release: owner=%b cyc=%b want 10 0", o_owner, o_cyc);
                end
            end
            if (c == 5) begin
                n_checks++;
                if (o_owner !== 2'b01 || o_cyc !== 1'b1 || o_adr !== AW'(32'h305)) begin
                    n_fail++; $display("FAIL prio_handover: owner=%b cyc=%b adr=%h want 01 1 305",
                                       o_owner, o_cyc, o_adr);
                end
            end
            tick();
        end
        auto_ack = 1'b0;
        s_ack = 1'b0;
    endtask

    task automatic test_outst_limit();
        m_acc_cnt = 0;
        for (int c = 0; c < 17; c++) begin
            a_cyc = !(m_acc_cnt >= 6 && m_outst == 0);
            a_stb = a_cyc && (m_acc_cnt < 6);
            a_we  = 1'b0;
            a_adr = AW'($urandom);
            s_ack = (c == 7) || (c >= 10 && m_outst > 0);
            #3;
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL limit_vec c%0d: got %h want %h", c, obs_vec(), exp_vec());
            end
            if (c == 5) begin
                n_checks++;
                if (o_a_stall !== 1'b1 || o_outst !== OW'(4)) begin
                    n_fail++; $display("FAIL limit_full: stall=%b outst=%0d want 1 4", o_a_stall, o_outst);
                end
            end
            if (c == 7) begin
                n_checks++;
                if (o_a_stall !== 1'b1 || o_a_ack !== 1'b1) begin
                    n_fail++; $display("FAIL limit_ack: stall=%b ack=%b want 1 1", o_a_stall, o_a_ack);
                end
            end
            if (c == 8) begin
                n_checks++;
                if (o_a_stall !== 1'b0 || o_outst !== OW'(3)) begin
                    n_fail++; $display("FAIL limit_resume: stall=%b outst=%0d want 0 3", o_a_stall, o_outst);
                end
            end
            if (c == 16) begin
                n_checks++;
                if (o_owner !== 2'b00 || o_outst !== '0) begin
                    n_fail++; $display("FAIL limit_end: owner=%b outst=%0d want 00 0", o_owner, o_outst);
                end
            end
            tick();
        end
        s_ack = 1'b0;
    endtask

    task automatic test_abort();
        for (int c = 0; c < 7; c++) begin
            b_cyc = (c <= 2); b_stb = (c <= 2); b_we = 1'b1; b_adr = AW'(32'h400 + c);
            a_cyc = (c <= 5); a_stb = (c == 4); a_we = 1'b0; a_adr = AW'(32'h500 + c);
            s_ack = (c == 4) || (c == 5);
            #3;
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL abort_vec c%0d: got %h want %h", c, obs_vec(), exp_vec());
            end
            if (c == 3) begin
                n_checks++;
                if (o_cyc !== 1'b0 || o_owner !== 2'b10 || o_outst !== OW'(2)) begin
                    n_fail++; $display("FAIL abort_drop: cyc=%b owner=%b outst=%0d want 0 10 2",
                                       o_cyc, o_owner, o_outst);
                end
            end
            if (c == 4) begin
                n_checks++;
                if (o_owner !== 2'b01 || o_outst !== '0 || o_a_ack !== 1'b0 || o_b_ack !== 1'b0) begin
                    n_fail++; $display("FAIL abort_stale: owner=%b outst=%0d a_ack=%b b_ack=%b want 01 0 0 0",
                                       o_owner, o_outst, o_a_ack, o_b_ack);
                end
            end
            if (c == 5) begin
                n_checks++;
                if (o_a_ack !== 1'b1 || o_b_ack !== 1'b0) begin
                    n_fail++; $display("FAIL abort_real_ack: a_ack=%b b_ack=%b want 1 0", o_a_ack, o_b_ack);
                end
            end
            tick();
        end
        s_ack = 1'b0;
    endtask

    task automatic test_err();
        for (int c = 0; c < 6; c++) begin
            b_cyc = (c <= 3); b_stb = (c <= 1); b_we = 1'b1;
            b_adr = AW'(32'h600); b_dat = 32'hDEAD_BEEF; b_sel = 4'h3;
            s_err = (c == 2);
            #3;
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL err_vec c%0d: got %h want %h", c, obs_vec(), exp_vec());
            end
            if (c == 2) begin
                n_checks++;
                if (o_b_err !== 1'b1 || o_a_err !== 1'b0 || o_b_ack !== 1'b0 || o_outst !== OW'(1)) begin
                    n_fail++; $display("FAIL err_pulse: b_err=%b a_err=%b b_ack=%b outst=%0d want 1 0 0 1",
                                       o_b_err, o_a_err, o_b_ack, o_outst);
                end
            end
            if (c == 3) begin
                n_checks++;
                if (o_b_err !== 1'b0 || o_outst !== '0 || o_owner !== 2'b10) begin
                    n_fail++; $display("FAIL err_after: b_err=%b outst=%0d owner=%b want 0 0 10",
                                       o_b_err, o_outst, o_owner);
                end
            end
            tick();
        end
        s_err = 1'b0;
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c < 5; c++) begin
            a_cyc = 1'b1; a_stb = (c <= 3); a_adr = AW'(32'h700 + c);
            #3;
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL rstmid_vec c%0d: got %h want %h", c, obs_vec(), exp_vec());
            end
            if (c < 4) tick();
        end
        n_checks++;
        if (o_outst !== OW'(3) || o_owner !== 2'b01) begin
            n_fail++; $display("FAIL rstmid_pre: outst=%0d owner=%b want 3 01", o_outst, o_owner);
        end
        #1;
        rst = 1'b0;
        #1;
        n_checks++;
        if (o_owner !== 2'b00 || o_outst !== '0 || o_a_stall !== 1'b1 ||
            o_b_stall !== 1'b1 || o_cyc !== 1'b0 || o_stb !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_async: owner=%b outst=%0d a_stall=%b b_stall=%b cyc=%b stb=%b want 00 0 1 1 0 0",
                     o_owner, o_outst, o_a_stall, o_b_stall, o_cyc, o_stb);
        end
        model_reset();
        idle_inputs();
        tick();
        rst = 1'b1;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            if (a_cyc) a_cyc = ($urandom_range(0, 9) != 0);
            else       a_cyc = ($urandom_range(0, 3) == 0);
            if (b_cyc) b_cyc = ($urandom_range(0, 9) != 0);
            else       b_cyc = ($urandom_range(0, 3) == 0);
            a_stb = a_cyc && ($urandom_range(0, 2) != 0);
            b_stb = b_cyc && ($urandom_range(0, 2) != 0);
            a_we = 1'($urandom); a_adr = AW'($urandom); a_dat = $urandom; a_sel = SELW'($urandom);
            b_we = 1'($urandom); b_adr = AW'($urandom); b_dat = $urandom; b_sel = SELW'($urandom);
            s_ack   = ($urandom_range(0, 2) == 0);
            s_err   = ($urandom_range(0, 9) == 0);
            s_stall = ($urandom_range(0, 3) == 0);
            #3;
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL random_vec c%0d: got %h want %h", c, obs_vec(), exp_vec());
            end
            tick();
        end
        idle_inputs();
        tick();
        tick();
        #3;
        n_checks++;
        if (o_owner !== 2'b00 || o_outst !== '0) begin
            n_fail++; $display("FAIL random_drain: owner=%b outst=%0d want 00 0", o_owner, o_outst);
        end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        auto_ack  = 1'b0;
        m_acc_cnt = 0;
        test_reset();
        test_single_a();
        test_prio_handover();
        test_outst_limit();
        test_abort();
        test_err();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
